vx_scoreboard_gate: RTL and testbench



---
 rtl/vx_scoreboard_gate_if.sv | 44 ++++
 rtl/vx_scoreboard_gate.sv | 152 +++++++++++++++
 tb/tb_vx_scoreboard_gate.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_scoreboard_gate_if.sv
// Valid/ready decoded-instruction handshake shared by the ibuffer, the
// scoreboard gate and operand fetch.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 1
`endif
`ifndef ISSUE_WARPS
`define ISSUE_WARPS (`NUM_WARPS / `ISSUE_WIDTH)
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

interface VX_ibuffer_if #(
    parameter int WIS_W      = (`ISSUE_WARPS > 1) ? $clog2(`ISSUE_WARPS) : 1,
    parameter int THREAD_CNT = `NUM_THREADS,
    parameter int REG_BITS   = `NR_BITS
) ();

    typedef struct packed {
        logic [WIS_W-1:0]      wis;
        logic [THREAD_CNT-1:0] tmask;
        logic [31:0]           pc;
        logic [7:0]            op;
        logic                  wb;
        logic [REG_BITS-1:0]   rd;
        logic [REG_BITS-1:0]   rs1;
        logic [REG_BITS-1:0]   rs2;
        logic [REG_BITS-1:0]   rs3;
    } data_t;

    logic  valid;
    data_t data;
    logic  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_scoreboard_gate.sv
// Register scoreboard: holds back instructions whose operands are still being
// written, and issues hazard-free ones through a one-entry registered slice.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 1
`endif
`ifndef ISSUE_WARPS
`define ISSUE_WARPS (`NUM_WARPS / `ISSUE_WIDTH)
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module vx_scoreboard_gate #(
    parameter int  ISSUE_WARPS = `ISSUE_WARPS,
    parameter int  THREAD_CNT  = `NUM_THREADS,
    parameter int  STALL_CTR_W = 32,
    localparam int ISSUE_WIS_W = (ISSUE_WARPS > 1) ? $clog2(ISSUE_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    VX_ibuffer_if.slave            ibuffer_in,
    VX_ibuffer_if.master           issue_out,
    input  logic                   wb_valid,
    input  logic [ISSUE_WIS_W-1:0] wb_wis,
    input  logic [`NR_BITS-1:0]    wb_rd,
    output logic [STALL_CTR_W-1:0] stall_count
);

    localparam int NUM_REGS = 1 << `NR_BITS;
    localparam int DATA_W   = ISSUE_WIS_W + THREAD_CNT + 32 + 8 + 1 + 4 * `NR_BITS;
    localparam logic [ISSUE_WIS_W:0] WARPS_LIM = (ISSUE_WIS_W + 1)'(ISSUE_WARPS);

    logic [ISSUE_WIS_W-1:0] in_wis;
    logic                   in_wb;
    logic [`NR_BITS-1:0]    in_rd;
    logic [`NR_BITS-1:0]    in_rs1;
    logic [`NR_BITS-1:0]    in_rs2;
    logic [`NR_BITS-1:0]    in_rs3;

    logic [ISSUE_WARPS-1:0][NUM_REGS-1:0] pending_q;
    logic [ISSUE_WARPS-1:0][NUM_REGS-1:0] pending_d;
    logic [ISSUE_WARPS-1:0][NUM_REGS-1:0] eff_pending;
    logic [NUM_REGS-1:0]                  in_row;

    logic in_wis_ok;
    logic wb_wis_ok;
    logic hazard;
    logic out_free;
    logic in_ready;
    logic accept;

    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;

    logic [STALL_CTR_W-1:0] stall_q;
    logic [STALL_CTR_W-1:0] stall_d;

    assign in_wis = ibuffer_in.data.wis;
    assign in_wb  = ibuffer_in.data.wb;
    assign in_rd  = ibuffer_in.data.rd;
    assign in_rs1 = ibuffer_in.data.rs1;
    assign in_rs2 = ibuffer_in.data.rs2;
    assign in_rs3 = ibuffer_in.data.rs3;

    assign in_wis_ok = {1'b0, in_wis} < WARPS_LIM;
    assign wb_wis_ok = {1'b0, wb_wis} < WARPS_LIM;

    // A writeback landing this cycle already counts as released.
    always_comb begin
        eff_pending = pending_q;
        if (wb_valid && wb_wis_ok) begin
            eff_pending[wb_wis][wb_rd] = 1'b0;
        end
    end

    always_comb begin
        in_row = '0;
        if (in_wis_ok) begin
            in_row = eff_pending[in_wis];
        end
        in_row[0] = 1'b0;
        hazard = ibuffer_in.valid
              && (in_row[in_rs1] || in_row[in_rs2] || in_row[in_rs3]
                  || (in_wb && in_row[in_rd]));
    end

    assign out_free         = !out_valid_q || issue_out.ready;
    assign in_ready         = !hazard && out_free;
    assign accept           = ibuffer_in.valid && in_ready;
    assign ibuffer_in.ready = in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ibuffer_in.data;
        end else if (issue_out.ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Starting from the cleared view makes a same-cycle set override the clear.
    always_comb begin
        pending_d = eff_pending;
        if (accept && in_wb && (in_rd != '0) && in_wis_ok) begin
            pending_d[in_wis][in_rd] = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign issue_out.valid = out_valid_q;
    assign issue_out.data  = out_data_q;
    assign stall_count     = stall_q;

    wis_in_range: assert property (@(posedge clk) disable iff (!reset)
        ibuffer_in.valid |-> in_wis_ok);

    wb_wis_in_range: assert property (@(posedge clk) disable iff (!reset)
        wb_valid |-> wb_wis_ok);

endmodule

// File: tb/tb_vx_scoreboard_gate.sv
// Directed bench for vx_scoreboard_gate: expected issues are queued at
// stimulus time and popped by an independent monitor on every output fire.
module tb_vx_scoreboard_gate;

    typedef struct packed {
        logic [1:0]  wis;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [7:0]  op;
        logic        wb;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
    } data_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_valid;
    logic [1:0] wb_wis;
    logic [4:0] wb_rd;
    logic [3:0] stall_count;

    int total = 0;
    int bad   = 0;
    data_t exp_q[$];

    VX_ibuffer_if #(.WIS_W(2), .THREAD_CNT(4), .REG_BITS(5)) ib_if ();
    VX_ibuffer_if #(.WIS_W(2), .THREAD_CNT(4), .REG_BITS(5)) ob_if ();

    vx_scoreboard_gate #(
        .ISSUE_WARPS (4),
        .THREAD_CNT  (4),
        .STALL_CTR_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ibuffer_in  (ib_if),
        .issue_out   (ob_if),
        .wb_valid    (wb_valid),
        .wb_wis      (wb_wis),
        .wb_rd       (wb_rd),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic data_t mk(input logic [1:0] wis, input logic wb, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rs3, input logic [31:0] pc);
        data_t d;
        d.wis   = wis;
        d.tmask = 4'hF;
        d.pc    = pc;
        d.op    = pc[7:0] ^ 8'h5A;
        d.wb    = wb;
        d.rd    = rd;
        d.rs1   = rs1;
        d.rs2   = rs2;
        d.rs3   = rs3;
        return d;
    endfunction

    task automatic drive(input data_t d);
        ib_if.valid = 1'b1;
        ib_if.data  = d;
        exp_q.push_back(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every output fire must match the oldest queued instruction.
    initial begin
        data_t e;
        forever begin
            @(negedge clk);
            if (reset && ob_if.valid && ob_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", ob_if.data, 128'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_data", ob_if.data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        ib_if.valid = 1'b0;
        ib_if.data  = '0;
        ob_if.ready = 1'b1;
        wb_valid    = 1'b0;
        wb_wis      = '0;
        wb_rd       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ob_if.valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_pending", dut.pending_q, 0);
        chk("rst_in_ready", ib_if.ready, 1);

        // First accept on the first edge after release, latency 1
        drive(mk(2'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 32'h100));
        reset = 1'b1;
        #1 chk("a_ready", ib_if.ready, 1);
        step();
        chk("a_latency", ob_if.valid, 1);
        ib_if.valid = 1'b0;
        sample();
        chk("a_pend_0_5", dut.pending_q[0][5], 1);

        // RAW hazard for three cycles, then resolved by same-cycle writeback
        step();
        drive(mk(2'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 32'h104));
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("b_stall_ready", ib_if.ready, 0);
            step();
        end
        wb_valid = 1'b1;
        wb_wis   = 2'd0;
        wb_rd    = 5'd5;
        sample();
        chk("b_bypass_ready", ib_if.ready, 1);
        chk("b_stall_count", stall_count, 3);
        step();
        wb_valid    = 1'b0;
        ib_if.valid = 1'b0;
        chk("b_issue_valid", ob_if.valid, 1);
        sample();
        chk("b_pend_cleared", dut.pending_q[0][5], 0);

        // Same register on another warp is independent; rd=0 never pends
        step();
        drive(mk(2'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 32'h108));
        sample();
        chk("c_ready", ib_if.ready, 1);
        step();
        drive(mk(2'd1, 1'b1, 5'd0, 5'd5, 5'd0, 5'd0, 32'h10C));
        sample();
        chk("d_pend_0_5", dut.pending_q[0][5], 1);
        chk("d_other_warp_ready", ib_if.ready, 1);
        step();
        ib_if.valid = 1'b0;
        sample();
        chk("d_rd0_not_pending", dut.pending_q[1], 0);
        step();
        wb_valid = 1'b1;
        wb_wis   = 2'd0;
        wb_rd    = 5'd5;
        step();
        wb_valid = 1'b0;
        sample();
        chk("wb_clear_all", dut.pending_q, 0);

        // Output backpressure: slice holds, no stall counted, then no bubble
        step();
        ob_if.ready = 1'b0;
        drive(mk(2'd3, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h200));
        sample();
        chk("e_ready", ib_if.ready, 1);
        step();
        drive(mk(2'd3, 1'b0, 5'd0, 5'd4, 5'd0, 5'd0, 32'h204));
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("hold_in_ready", ib_if.ready, 0);
            chk("hold_out_valid", ob_if.valid, 1);
            chk("hold_out_data", ob_if.data, mk(2'd3, 1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 32'h200));
            chk("hold_stall_count", stall_count, 3);
            step();
        end
        ob_if.ready = 1'b1;
        sample();
        chk("f_ready", ib_if.ready, 1);
        step();
        chk("f_b2b_valid", ob_if.valid, 1);
        drive(mk(2'd2, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0, 32'h208));
        sample();
        chk("g_ready", ib_if.ready, 1);
        step();
        ib_if.valid = 1'b0;
        chk("g_b2b_valid", ob_if.valid, 1);
        sample();
        step();
        chk("g_valid_drops", ob_if.valid, 0);

        // Same-cycle set and clear of (2,7): set wins
        ob_if.ready = 1'b0;
        drive(mk(2'd2, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 32'h300));
        wb_valid = 1'b1;
        wb_wis   = 2'd2;
        wb_rd    = 5'd7;
        sample();
        chk("h_ready", ib_if.ready, 1);
        step();
        wb_valid = 1'b0;
        chk("h_pend_2_7", dut.pending_q[2][7], 1);
        chk("h_held_valid", ob_if.valid, 1);

        // Hazard plus full output: counter climbs to 14 then saturates at 15
        drive(mk(2'd2, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0, 32'h304));
        for (int i = 0; i < 11; i++) begin
            sample();
            chk("j_stall_ready", ib_if.ready, 0);
            step();
        end
        sample();
        chk("stall_pre_sat", stall_count, 14);
        repeat (3) step();
        sample();
        chk("stall_saturated", stall_count, 15);

        // Asynchronous reset mid-stall discards the held instruction
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", ob_if.valid, 0);
        chk("midrst_stall", stall_count, 0);
        chk("midrst_pending", dut.pending_q, 0);
        chk("midrst_in_ready", ib_if.ready, 1);
        exp_q.delete();

        @(negedge clk);
        ob_if.ready = 1'b1;
        drive(mk(2'd1, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 32'h400));
        reset = 1'b1;
        #1 chk("k_ready", ib_if.ready, 1);
        step();
        chk("k_latency", ob_if.valid, 1);
        ib_if.valid = 1'b0;
        sample();
        chk("k_pend_1_9", dut.pending_q[1][9], 1);
        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
